// File: rtl/bb8051_fetch.sv
// bb8051 instruction fetch: reads opcode bytes from program ROM, sizes each
// instruction from the MCS-51 opcode map and presents op1..op3 to the decoder.
module bb8051_fetch #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_rd,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [7:0]  op1_out,
  output logic [7:0]  op2_out,
  output logic [7:0]  op3_out,
  output logic [1:0]  op_len,
  output logic        op_valid,
  input  logic        decoder_wait,
  output logic [15:0] next_pc,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_B1,
    S_B2,
    S_B3,
    S_VALID
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  op1_q, op1_d;
  logic [7:0]  op2_q, op2_d;
  logic [7:0]  op3_q, op3_d;
  logic [1:0]  len_q, len_d;
  logic [1:0]  rom_len;
  logic        fetch;

  // MCS-51 instruction length by opcode; anything not listed is 1 byte.
  function automatic logic [1:0] lut_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    casez (op)
      8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63,
      8'h75, 8'h85, 8'h90, 8'hD5,
      8'b1011_01??, 8'b1011_1???:
        len = 2'd3;
      8'b????_0001,
      8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35,
      8'h40, 8'h42, 8'h44, 8'h45, 8'h50, 8'h52, 8'h54, 8'h55,
      8'h60, 8'h62, 8'h64, 8'h65, 8'h70, 8'h72, 8'h74,
      8'b0111_011?, 8'b0111_1???,
      8'h80, 8'h82, 8'b1000_011?, 8'b1000_1???,
      8'h92, 8'h94, 8'h95,
      8'hA0, 8'hA2, 8'b1010_011?, 8'b1010_1???,
      8'hB0, 8'hB2, 8'hC0, 8'hC2, 8'hC5,
      8'hD0, 8'hD2, 8'b1101_1???,
      8'hE5, 8'hF5:
        len = 2'd2;
      default:
        len = 2'd1;
    endcase
    return len;
  endfunction

  assign rom_len = lut_len(rom_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RESET;
      op1_q   <= '0;
      op2_q   <= '0;
      op3_q   <= '0;
      len_q   <= 2'd1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      op3_q   <= op3_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    op3_d   = op3_q;
    len_d   = len_q;
    pc_d    = fetch ? pc_q + 16'd1 : pc_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_B1;
      S_B1: begin
        op1_d   = rom_data;
        len_d   = rom_len;
        op2_d   = '0;
        op3_d   = '0;
        state_d = (rom_len == 2'd1) ? S_VALID : S_B2;
      end
      S_B2: begin
        op2_d   = rom_data;
        state_d = (len_q == 2'd2) ? S_VALID : S_B3;
      end
      S_B3: begin
        op3_d   = rom_data;
        state_d = S_VALID;
      end
      S_VALID: begin
        if (!decoder_wait) begin
          state_d = S_B1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A redirect abandons whatever is being assembled; the refetch starts clean.
    if (pc_load && state_q != S_IDLE) begin
      pc_d    = pc_load_val;
      state_d = S_FETCH;
    end
  end

  always_comb begin
    fetch = 1'b0;
    case (state_q)
      S_FETCH: fetch = !pc_load;
      S_B1:    fetch = !pc_load && (rom_len != 2'd1);
      S_B2:    fetch = !pc_load && (len_q == 2'd3);
      S_VALID: fetch = !pc_load && !decoder_wait;
      default: fetch = 1'b0;
    endcase
    rom_rd   = rst ? 1'b0 : fetch;
    rom_addr = rst ? PC_RESET : pc_q;
    op_valid = !rst && (state_q == S_VALID);
  end

  assign op1_out = op1_q;
  assign op2_out = op2_q;
  assign op3_out = op3_q;
  assign op_len  = len_q;
  assign next_pc = pc_q;

endmodule
